// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core: captures decode state, forwards
// MEM/WB results into the ALU operands, and turns load-use hazards into stall + bubble.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            ALUSrcD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [REGW-1:0] RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteW,
    input  logic            FlushE,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [2:0]      ALUControlE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [REGW-1:0] RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic            StallF,
    output logic            StallD,
    output logic [CNTW-1:0] StallCount
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic            regwrite;
        logic [1:0]      resultsrc;
        logic            memwrite;
        logic            alusrc;
        logic            branch;
        logic            jump;
        logic [2:0]      aluctl;
    } ex_regs_t;

    localparam logic [CNTW-1:0] cnt_one = CNTW'(1);

    ex_regs_t        d_regs;
    ex_regs_t        e_regs;
    logic            lwstall;
    logic            bubble;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign d_regs = '{
        rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD,
        rs1: Rs1D, rs2: Rs2D, rd: RdD,
        regwrite: RegWriteD, resultsrc: ResultSrcD, memwrite: MemWriteD,
        alusrc: ALUSrcD, branch: BranchD, jump: JumpD, aluctl: ALUControlD
    };

    // A load in EX whose destination is read by the instruction in decode cannot be forwarded in time.
    assign lwstall = (e_regs.resultsrc == 2'b01) && (e_regs.rd != '0) &&
                     ((e_regs.rd == Rs1D) || (e_regs.rd == Rs2D));
    assign StallF  = lwstall;
    assign StallD  = lwstall;
    assign bubble  = lwstall || FlushE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_regs     <= '0;
            StallCount <= '0;
        end else begin
            // NOTE: non-blocking so the whole E bundle and the counter sample pre-edge values together.
            e_regs <= bubble ? '0 : d_regs;
            if (lwstall && (StallCount != '1)) begin
                StallCount <= StallCount + cnt_one;
            end
        end
    end

    // MEM is the younger producer, so it wins over WB; x0 is never a forwarding source.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        fwd_a = e_regs.rd1;
        fwd_b = e_regs.rd2;
        if (RegWriteM && (RdM != '0) && (RdM == e_regs.rs1)) begin
            fwd_a = ALUResultM;
        end else if (RegWriteW && (RdW != '0) && (RdW == e_regs.rs1)) begin
            fwd_a = ResultW;
        end
        if (RegWriteM && (RdM != '0) && (RdM == e_regs.rs2)) begin
            fwd_b = ALUResultM;
        end else if (RegWriteW && (RdW != '0) && (RdW == e_regs.rs2)) begin
            fwd_b = ResultW;
        end
    end

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign SrcBE       = e_regs.alusrc ? e_regs.imm : fwd_b;
    assign ALUControlE = e_regs.aluctl;
    assign RegWriteE   = e_regs.regwrite;
    assign ResultSrcE  = e_regs.resultsrc;
    assign MemWriteE   = e_regs.memwrite;
    assign BranchE     = e_regs.branch;
    assign JumpE       = e_regs.jump;
    assign RdE         = e_regs.rd;
    assign PCE         = e_regs.pc;
    assign ImmExtE     = e_regs.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against
// an instruction-level model of the EX slot; a second instance with CNTW=2 covers saturation.
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
    logic [REGW-1:0] Rs1D, Rs2D, RdD, RdM, RdW;
    logic RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, RegWriteM, RegWriteW, FlushE;
    logic [1:0] ResultSrcD;
    logic [2:0] ALUControlD;

    logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
    logic [2:0] ALUControlE;
    logic RegWriteE, MemWriteE, BranchE, JumpE, StallF, StallD;
    logic [1:0] ResultSrcE;
    logic [REGW-1:0] RdE;
    logic [15:0] StallCount;

    logic [XLEN-1:0] s_SrcAE, s_SrcBE, s_WriteDataE, s_PCE, s_ImmExtE;
    logic [2:0] s_ALUControlE;
    logic s_RegWriteE, s_MemWriteE, s_BranchE, s_JumpE, s_StallF, s_StallD;
    logic [1:0] s_ResultSrcE;
    logic [REGW-1:0] s_RdE;
    logic [1:0] s_StallCount;

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD),
        .ALUControlD(ALUControlD), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .FlushE(FlushE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .ALUControlE(ALUControlE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .RdE(RdE), .PCE(PCE), .ImmExtE(ImmExtE), .StallF(StallF), .StallD(StallD),
        .StallCount(StallCount)
    );

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD),
        .ALUControlD(ALUControlD), .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .FlushE(FlushE),
        .SrcAE(s_SrcAE), .SrcBE(s_SrcBE), .WriteDataE(s_WriteDataE), .ALUControlE(s_ALUControlE),
        .RegWriteE(s_RegWriteE), .ResultSrcE(s_ResultSrcE), .MemWriteE(s_MemWriteE),
        .BranchE(s_BranchE), .JumpE(s_JumpE), .RdE(s_RdE), .PCE(s_PCE), .ImmExtE(s_ImmExtE),
        .StallF(s_StallF), .StallD(s_StallD), .StallCount(s_StallCount)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: the instruction currently occupying EX, plus the number of load-use stalls seen.
    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite, alusrc, branch, jump;
        logic [2:0]  aluctl;
    } ex_t;
    ex_t m;
    int  n_lw;

    function automatic logic exp_lw();
        return (m.resultsrc == 2'b01) && (m.rd != 0) && ((m.rd == Rs1D) || (m.rd == Rs2D));
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (RegWriteM && RdM != 0 && RdM == rs) return ALUResultM;
        if (RegWriteW && RdW != 0 && RdW == rs) return ResultW;
        return regval;
    endfunction

    task automatic tick();
        logic lw;
        @(posedge clk);
        lw = exp_lw();
        if (lw) n_lw++;
        if (lw || FlushE) m = '0;
        else m = '{rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD, rs1: Rs1D, rs2: Rs2D, rd: RdD,
                   regwrite: RegWriteD, resultsrc: ResultSrcD, memwrite: MemWriteD,
                   alusrc: ALUSrcD, branch: BranchD, jump: JumpD, aluctl: ALUControlD};
        #1;
    endtask

    task automatic clear_inputs();
        RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; ALUSrcD = 0; BranchD = 0; JumpD = 0;
        ALUControlD = 0; ALUResultM = 0; RdM = 0; RegWriteM = 0; ResultW = 0; RdW = 0;
        RegWriteW = 0; FlushE = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; m = '0; n_lw = 0;
        #2;
        rst_n = 1;
    endtask

    // Puts a load to x4 into EX, then presents a consumer in decode.
    task automatic load_then_use(input logic flush);
        clear_inputs();
        ResultSrcD = 2'b01; RdD = 5'd4; RegWriteD = 1;
        tick();
        clear_inputs();
        Rs2D = 5'd4; RD2D = 32'h5; RegWriteD = 1; RdD = 5'd7; ALUControlD = 3'd2; FlushE = flush;
        #1;
    endtask

    task automatic test_reset();
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
        Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
        RegWriteD = 1; ResultSrcD = 2'($urandom); MemWriteD = 1; ALUSrcD = 0;
        BranchD = 1; JumpD = 1; ALUControlD = 3'd5;
        rst_n = 0; m = '0; n_lw = 0;
        @(posedge clk); #1;
        checks++;
        if ({RdE, PCE, ImmExtE, ALUControlE, RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE,
             SrcAE, SrcBE, WriteDataE} !== '0) begin
            errors++; $display("FAIL reset_eregs: got nonzero (PCE=%0h RdE=%0h) expected 0", PCE, RdE);
        end
        checks++;
        if ({StallF, StallD} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b expected 00", {StallF, StallD}); end
        checks++;
        if (StallCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", StallCount); end
        @(negedge clk); rst_n = 1;
        tick();
        checks++;
        if ({PCE, ImmExtE, RdE, ALUControlE, SrcAE} !== {PCD, ImmExtD, RdD, 3'd5, RD1D}) begin
            errors++; $display("FAIL reset_capture: got PCE=%0h RdE=%0h SrcAE=%0h expected PCE=%0h RdE=%0h SrcAE=%0h",
                               PCE, RdE, SrcAE, PCD, RdD, RD1D);
        end
        checks++;
        if ({RegWriteE, MemWriteE, BranchE, JumpE} !== 4'b1111) begin
            errors++; $display("FAIL reset_capture_ctl: got %b expected 1111", {RegWriteE, MemWriteE, BranchE, JumpE});
        end
    endtask

    task automatic test_passthrough();
        do_reset(); clear_inputs();
        RD1D = 5; RD2D = 7; ALUSrcD = 0; ALUControlD = 3'd1; Rs1D = 5'd1; Rs2D = 5'd2;
        tick();
        checks++;
        if (SrcAE !== 32'd5) begin errors++; $display("FAIL pass_srca: got %0h expected 5", SrcAE); end
        checks++;
        if (SrcBE !== 32'd7) begin errors++; $display("FAIL pass_srcb: got %0h expected 7", SrcBE); end
        checks++;
        if (ALUControlE !== 3'd1) begin errors++; $display("FAIL pass_aluctl: got %0d expected 1", ALUControlE); end
    endtask

    task automatic test_forward_priority();
        do_reset(); clear_inputs();
        Rs1D = 5'd3; RD1D = 32'h11;
        tick();
        RdM = 5'd3; RegWriteM = 1; ALUResultM = 32'hAA; RdW = 5'd3; RegWriteW = 1; ResultW = 32'hBB;
        #1;
        checks++;
        if (SrcAE !== 32'hAA) begin errors++; $display("FAIL fwd_mem_first: got %0h expected aa", SrcAE); end
        RdM = 5'd0;
        #1;
        checks++;
        if (SrcAE !== 32'hBB) begin errors++; $display("FAIL fwd_x0_mem: got %0h expected bb", SrcAE); end
        RdW = 5'd0;
        #1;
        checks++;
        if (SrcAE !== 32'h11) begin errors++; $display("FAIL fwd_x0_both: got %0h expected 11", SrcAE); end
    endtask

    task automatic test_imm_select();
        do_reset(); clear_inputs();
        ALUSrcD = 1; ImmExtD = 32'h10; Rs2D = 5'd6; RD2D = 32'h22;
        tick();
        RdM = 5'd6; RegWriteM = 1; ALUResultM = 32'h99;
        #1;
        checks++;
        if (SrcBE !== 32'h10) begin errors++; $display("FAIL imm_srcb: got %0h expected 10", SrcBE); end
        checks++;
        if (WriteDataE !== 32'h99) begin errors++; $display("FAIL imm_wdata: got %0h expected 99", WriteDataE); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_then_use(1'b0);
        checks++;
        if ({StallF, StallD} !== 2'b11) begin errors++; $display("FAIL lu_stall: got %b expected 11", {StallF, StallD}); end
        tick();
        checks++;
        if ({RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUControlE, RdE} !== '0) begin
            errors++; $display("FAIL lu_bubble: got RegWriteE=%b ResultSrcE=%b RdE=%0d expected all 0", RegWriteE, ResultSrcE, RdE);
        end
        checks++;
        if (StallCount !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", StallCount); end
        checks++;
        if (StallF !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", StallF); end
        RdW = 5'd4; RegWriteW = 1; ResultW = 32'h1234;
        tick();
        checks++;
        if ({RdE, ALUControlE, RegWriteE} !== {5'd7, 3'd2, 1'b1}) begin
            errors++; $display("FAIL lu_capture: got RdE=%0d ALUControlE=%0d expected RdE=7 ALUControlE=2", RdE, ALUControlE);
        end
        checks++;
        if ({SrcBE, WriteDataE} !== {32'h1234, 32'h1234}) begin
            errors++; $display("FAIL lu_fwd_w: got SrcBE=%0h WriteDataE=%0h expected 1234", SrcBE, WriteDataE);
        end
        checks++;
        if (StallCount !== 16'd1) begin errors++; $display("FAIL lu_count_hold: got %0d expected 1", StallCount); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        load_then_use(1'b1);
        checks++;
        if ({StallF, StallD} !== 2'b11) begin errors++; $display("FAIL fs_stall: got %b expected 11", {StallF, StallD}); end
        tick();
        FlushE = 0;
        checks++;
        if ({RegWriteE, ResultSrcE, RdE, StallCount} !== {1'b0, 2'b00, 5'd0, 16'd1}) begin
            errors++; $display("FAIL fs_bubble: got RdE=%0d count=%0d expected RdE=0 count=1", RdE, StallCount);
        end
        tick();
        checks++;
        if ({RdE, StallCount} !== {5'd7, 16'd1}) begin
            errors++; $display("FAIL fs_single: got RdE=%0d count=%0d expected RdE=7 count=1", RdE, StallCount);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_then_use(1'b0);
            tick();
            tick();
        end
        checks++;
        if (s_StallCount !== 2'd3) begin errors++; $display("FAIL sat_cntw2: got %0d expected 3", s_StallCount); end
        checks++;
        if (StallCount !== 16'd5) begin errors++; $display("FAIL sat_cntw16: got %0d expected 5", StallCount); end
    endtask

    task automatic test_reset_midstall();
        do_reset();
        load_then_use(1'b0);
        tick(); tick();
        load_then_use(1'b0);
        checks++;
        if ({StallF, StallCount} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL rm_pre: got StallF=%b count=%0d expected 1 and 1", StallF, StallCount);
        end
        rst_n = 0; m = '0; n_lw = 0;
        #1;
        checks++;
        if ({StallF, StallD, ResultSrcE, RdE, StallCount} !== '0) begin
            errors++; $display("FAIL rm_async: got StallF=%b StallD=%b RdE=%0d count=%0d expected 0", StallF, StallD, RdE, StallCount);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_random();
        logic [31:0] got [16];
        logic [31:0] exp [16];
        string       nm  [16];
        int          cnt_exp;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7)); RdD = 5'($urandom_range(0, 7));
            RegWriteD = 1'($urandom); ResultSrcD = 2'($urandom); MemWriteD = 1'($urandom);
            ALUSrcD = 1'($urandom); BranchD = 1'($urandom); JumpD = 1'($urandom);
            ALUControlD = 3'($urandom);
            ALUResultM = $urandom; RdM = 5'($urandom_range(0, 7)); RegWriteM = 1'($urandom);
            ResultW = $urandom; RdW = 5'($urandom_range(0, 7)); RegWriteW = 1'($urandom);
            FlushE = ($urandom_range(0, 7) == 0);
            #1;
            cnt_exp = (n_lw > 65535) ? 65535 : n_lw;
            nm[0]  = "SrcAE";       got[0]  = SrcAE;           exp[0]  = exp_fwd(m.rs1, m.rd1);
            nm[1]  = "WriteDataE";  got[1]  = WriteDataE;      exp[1]  = exp_fwd(m.rs2, m.rd2);
            nm[2]  = "SrcBE";       got[2]  = SrcBE;           exp[2]  = m.alusrc ? m.imm : exp_fwd(m.rs2, m.rd2);
            nm[3]  = "ALUControlE"; got[3]  = 32'(ALUControlE); exp[3]  = 32'(m.aluctl);
            nm[4]  = "RegWriteE";   got[4]  = 32'(RegWriteE);  exp[4]  = 32'(m.regwrite);
            nm[5]  = "ResultSrcE";  got[5]  = 32'(ResultSrcE); exp[5]  = 32'(m.resultsrc);
            nm[6]  = "MemWriteE";   got[6]  = 32'(MemWriteE);  exp[6]  = 32'(m.memwrite);
            nm[7]  = "BranchE";     got[7]  = 32'(BranchE);    exp[7]  = 32'(m.branch);
            nm[8]  = "JumpE";       got[8]  = 32'(JumpE);      exp[8]  = 32'(m.jump);
            nm[9]  = "RdE";         got[9]  = 32'(RdE);        exp[9]  = 32'(m.rd);
            nm[10] = "PCE";         got[10] = PCE;             exp[10] = m.pc;
            nm[11] = "ImmExtE";     got[11] = ImmExtE;         exp[11] = m.imm;
            nm[12] = "StallF";      got[12] = 32'(StallF);     exp[12] = 32'(exp_lw());
            nm[13] = "StallD";      got[13] = 32'(StallD);     exp[13] = 32'(exp_lw());
            nm[14] = "StallCount";  got[14] = 32'(StallCount); exp[14] = 32'(cnt_exp);
            nm[15] = "StallCount2"; got[15] = 32'(s_StallCount); exp[15] = 32'((n_lw > 3) ? 3 : n_lw);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand[%0d] %s: got %0h expected %0h", cyc, nm[i], got[i], exp[i]);
                end
            end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_passthrough();
        test_forward_priority();
        test_imm_select();
        test_load_use();
        test_flush_stall();
        test_saturation();
        test_reset_midstall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
